// File: rtl/pair_triple_vector_gen.sv
// Stimulus source for the pair/triple detector: streams 3-bit vectors plus the
// expected detector output over valid/ready, filtered by mode and bounded by count.
module pair_triple_vector_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_vec,
  output logic             out_expect,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [CNT_W:0]   target;
  logic [CNT_W:0]   emitted;
  logic [CNT_W:0]   emitted_nxt;
  logic [2:0]       first_vec;
  logic [2:0]       next_vec;

  function automatic logic majority(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic is_match(input logic [1:0] m, input logic [2:0] v);
    logic r;
    case (m)
      2'b00:   r = 1'b1;
      2'b01:   r = majority(v);
      2'b10:   r = ~majority(v);
      default: r = &v;
    endcase
    return r;
  endfunction

  // Lowest k in 0..7 such that base+offset+k matches; wraps modulo 8.
  function automatic logic [2:0] scan(input logic [1:0] m, input logic [2:0] base,
                                      input logic [2:0] offset);
    logic [2:0] res;
    logic [2:0] cand;
    res = base;
    for (int k = 7; k >= 0; k--) begin
      cand = base + offset + 3'(k);
      if (is_match(m, cand)) res = cand;
    end
    return res;
  endfunction

  assign first_vec   = scan(mode, 3'b000, 3'd0);
  assign next_vec    = scan(mode_q, out_vec, 3'd1);
  assign emitted_nxt = emitted + (CNT_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 2'b00;
      target     <= '0;
      emitted    <= '0;
      out_valid  <= 1'b0;
      out_vec    <= 3'b000;
      out_expect <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= mode;
            target     <= (count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count};
            emitted    <= '0;
            out_vec    <= first_vec;
            out_expect <= majority(first_vec);
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            emitted <= emitted_nxt;
            if (emitted_nxt == target) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_vec    <= next_vec;
              out_expect <= majority(next_vec);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_triple_vector_gen.sv
// Scoreboard bench for pair_triple_vector_gen: expected vectors are queued at
// start time and popped whenever the DUT completes a handshake.
module tb_pair_triple_vector_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] count = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_vec;
  logic       out_expect;
  logic       busy;
  logic       done;

  typedef struct {
    logic [2:0] vec;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         xfer_cnt = 0;
  logic       held_valid = 1'b0;
  logic [2:0] held_vec = 3'b000;

  pair_triple_vector_gen #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .count(count),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_expect(out_expect), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_pred(input logic [1:0] m, input logic [2:0] v);
    int ones;
    ones = v[0] + v[1] + v[2];
    case (m)
      2'b00:   return 1'b1;
      2'b01:   return ones >= 2;
      2'b10:   return ones < 2;
      default: return v == 3'b111;
    endcase
  endfunction

  task automatic push_expected(input logic [1:0] m, input int n);
    logic [2:0] v;
    exp_t e;
    int ones;
    v = 3'b000;
    while (!model_pred(m, v)) v = v + 3'd1;
    for (int i = 0; i < n; i++) begin
      ones  = v[0] + v[1] + v[2];
      e.vec = v;
      e.e   = (ones >= 2);
      sb.push_back(e);
      v = v + 3'd1;
      while (!model_pred(m, v)) v = v + 3'd1;
    end
  endtask

  // Handshake monitor: pops the scoreboard and checks stability while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (held_valid) check("stable_vec", out_vec, held_vec);
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_xfer", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_vec", out_vec, mon_e.vec);
          check("out_expect", out_expect, mon_e.e);
        end
        xfer_cnt++;
      end
      held_valid = !out_ready;
      held_vec   = out_vec;
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic run_test(input logic [1:0] m, input logic [3:0] c,
                          input bit toggle, input bit hold_start);
    int n;
    int cyc;
    bit seen;
    n = (c == 0) ? 16 : c;
    push_expected(m, n);
    xfer_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; count = c;
    @(posedge clk); #1;
    if (!hold_start) begin
      start = 1'b0;
      mode  = ~m;
      count = c + 4'd5;
    end
    check("first_valid", out_valid, 1);
    check("busy_run", busy, 1);
    out_ready = 1'b1;
    seen = 0;
    cyc  = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        seen = 1;
        break;
      end
      if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1'b0;
    check("done_seen", seen, 1);
    check("xfer_count", xfer_cnt, n);
    check("sb_empty", sb.size(), 0);
    check("cycles_to_done", cyc, toggle ? 2 * n - 1 : n);
    check("valid_in_done", out_valid, 0);
    check("busy_in_done", busy, 1);
    @(posedge clk); #1;
    check("done_pulse_end", done, 0);
    check("busy_idle", busy, 0);
    if (hold_start) begin
      @(posedge clk); #1;
      check("restart_valid", out_valid, 1);
      check("restart_vec", out_vec, 3'b111);
      check("restart_expect", out_expect, 1);
      start = 1'b0;
    end
  endtask

  initial begin
    int waited;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_vec", out_vec, 0);
    check("rst_expect", out_expect, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Abort a run after two transfers.
    push_expected(2'b00, 8);
    xfer_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b00; count = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (xfer_cnt < 2 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("abort_xfers", xfer_cnt, 2);
    rst_n = 1'b0;
    out_ready = 1'b0;
    #1;
    sb.delete();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_done_hold", done, 0);
    end
    rst_n = 1'b1;

    run_test(2'b00, 4'd3, 1'b0, 1'b0);
    run_test(2'b00, 4'd0, 1'b0, 1'b0);
    run_test(2'b01, 4'd5, 1'b0, 1'b0);
    run_test(2'b10, 4'd6, 1'b1, 1'b0);
    run_test(2'b11, 4'd3, 1'b0, 1'b1);

    rst_n = 1'b0;
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pair_triple_vector_gen.md
Name: pair_triple_vector_gen

Overview:
Sequential stimulus source that is the driving end of the pair/triple detector interface. It emits a stream of 3-bit input vectors (in0..in2) with the expected detector output, over a valid/ready handshake. A mode filter restricts the stream to all vectors, majority-true vectors, majority-false vectors, or the all-ones triple. It sits beside the detector in the TinyTapeout top so the silicon can self-exercise the detector.

Parameters:
CNT_W, 4, width of the vector-count request; a count value of 0 means 2^CNT_W vectors.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
mode  input  2  filter: 00 all, 01 positive (two or more ones), 10 negative (fewer than two ones), 11 triple (all three ones)
count  input  CNT_W  number of vectors to emit; 0 means 2^CNT_W
out_valid  output  1  out_vec/out_expect hold a vector
out_ready  input  1  consumer accepts the vector
out_vec  output  3  vector; bit0=in0, bit1=in1, bit2=in2
out_expect  output  1  expected detector output for out_vec (1 if popcount(out_vec) >= 2)
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; out_valid=0, out_vec=000, out_expect=0, busy=0, done=0; internal counters=0.
- Deassertion of rst_n takes effect at the next clock edge. Reset mid-run aborts the run immediately; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at a clock edge, latch mode and count (0 maps to 2^CNT_W), clear the emitted counter, load out_vec with the first matching value scanning upward from 000, and go to RUN. start is ignored in RUN and DONE.
- RUN: out_valid=1. out_vec and out_expect stay stable until a handshake, which is out_valid&out_ready at a clock edge. out_valid is never dropped before a handshake.
- Handshake in RUN: the emitted counter increments. If the new count equals the latched count, go to DONE with out_valid=0 next cycle. Otherwise load out_vec with the next matching value above the current one, wrapping 111->000, found combinationally over the 8 rotations.
- Match sequences:
  - mode 00: 0,1,2,...,7,0,...
  - mode 01: 3,5,6,7,3,...
  - mode 10: 0,1,2,4,0,...
  - mode 11: 7,7,...
- First valid appears the cycle after start is accepted; throughput is one vector per cycle while out_ready=1.
- out_expect is a registered copy of (popcount(out_vec) >= 2), updated in the same cycle as out_vec.
- DONE: done=1 for exactly one cycle, busy=1; then IDLE with busy=0. A start asserted during DONE is ignored.
- mode and count changes during RUN have no effect. out_vec holds its last value in IDLE and DONE.
- The emitted counter is CNT_W+1 bits wide so that a full 2^CNT_W run terminates correctly.

Test Plan:
- Reset mid-RUN after 2 transfers -> out_valid=0, busy=0, done stays 0; a new start with mode=00, count=3 then emits 000,001,010.
- start, mode=00, count=0 (16), out_ready=1 -> out_vec 0..7,0..7 on consecutive cycles; out_expect=0,0,0,1,0,1,1,1 repeating; done pulses once the cycle after the 16th transfer.
- start, mode=01, count=5, out_ready=1 -> 3,5,6,7,3, all with out_expect=1; then done=1 for one cycle; busy falls the following cycle.
- mode=10, count=6, out_ready toggling 1,0,1,0 -> out_vec stays stable while ready=0; accepted sequence is 0,1,2,4,0,1, all with out_expect=0; the count of transfers is exact.
- mode=11, count=3, with start held high throughout -> three transfers of 111 with out_expect=1, done pulse, then a new run starts from IDLE. This checks that start is ignored during RUN and DONE and that the new run begins at 111.
